seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Time-multiplexed driver for a DIGITS-wide common-anode seven-segment display. It generalises our 2-bit, single-digit segment encoder to full hexadecimal decode over a parametrised digit count. It adds a scan prescaler, tear-free frame-synchronous value loading, per-digit decimal points and a global blank. It sits between the counter/datapath logic and the board's segment and anode pins.

## Interface
- DIGITS, 4, number of digits (≥2)
- SCAN_DIV, 50000, clock cycles each digit is held (≥1)
- clk  in  1  system clock; one clock, all state on rising edge
- reset  in  1  synchronous, active-high
- value  in  4*DIGITS  hex nibbles; nibble i drives digit i (digit 0 = LSB = rightmost)
- load  in  1  capture value into staging register this cycle
- dp_in  in  DIGITS  decimal point request per digit, active-high
- blank  in  1  force all anodes off while high
- seg  out  7  segments, active-low, bit6=a … bit0=g
- dp  out  1  decimal point, active-low
- an  out  DIGITS  anode enables, active-low, one-hot-cold
- frame_start  out  1  one-cycle pulse when scan wraps to digit 0

## Operation
- Prescaler counts 0..SCAN_DIV-1; terminal count = tick. On a tick, digit index advances and wraps DIGITS-1 → 0. Index width is max(1, $clog2(DIGITS)).
- Staging: a cycle with load=1 captures value into the staging register and sets pending. If several loads occur before a wrap, the last one wins.
- Shadow update: on the wrap tick, if pending, staging → shadow and pending clears. If load=1 on the wrap tick itself, the incoming value goes straight to shadow and pending is cleared. A displayed frame never mixes two values.
- frame_start is asserted on the wrap tick, whether or not pending is set.
- Decode is active-low hex: 0=000_0001, 1=100_1111, 2=001_0010, 3=000_0110, 4=100_1100, 5=010_0100, 6=010_0000, 7=000_1111, 8=000_0000, 9=000_0100, A=000_1000, b=110_0000, C=011_0001, d=100_0010, E=011_0000, F=011_1000.
- an drives 0 on the current index bit only, and all ones when blank=1. When blank=1, seg and dp still track the current digit.
- dp = ~dp_in[index].

## Timing
- Reset values: seg=7'b111_1111, dp=1, an=all ones, frame_start=0. Index=0, prescaler=0, shadow=0, staging=0, pending=0.
- Outputs are registered, so seg/an/dp reflect the index and shadow one cycle later. In the first cycle after reset deasserts, an=~1 and seg shows "0".
- Each digit is displayed for exactly SCAN_DIV cycles. Full frame = DIGITS*SCAN_DIV cycles.
- With SCAN_DIV=1, a tick occurs every cycle.
- load-to-display latency: at most one frame plus one cycle.
- Reset asserted mid-frame returns all state to reset values on the next edge and discards any pending load.
- blank has one-cycle latency to an.

## Configuration
- LEADING_ZERO_BLANK_EN defined: zero digits above the most significant non-zero shadow nibble show seg=111_1111. Digit 0 is never blanked. dp is still driven from dp_in, and an scanning is unchanged.
- Not defined: every digit is decoded, including leading zeros.

## Structure
- Package seg7_pkg holds:
  - the 16-entry segment constant table
  - SEG_OFF = 7'b111_1111
  - the bit-order definition (bit6=a)
- Sub-module hex_seg7_decoder: combinational 4-bit → 7-bit lookup from the package table, instantiated once on the muxed nibble.
- Top-level holds prescaler, index, staging/shadow/pending, output registers and the optional blanking logic.

## Test plan
Unless stated otherwise, DIGITS=4 and SCAN_DIV=4.
- Reset: hold reset 3 cycles → seg=111_1111, an=1111, dp=1, frame_start=0. First cycle after release → an=1110, seg=000_0001.
- Scan: value=16'h3210 loaded before first wrap, free-run two frames → each digit held 4 cycles. Order an=1110,1101,1011,0111 with seg=000_0001, 100_1111, 001_0010, 000_0110. frame_start pulses every 16 cycles.
- Tear-free load: load 16'hABCD mid-frame while 16'h1234 is displayed → remaining digits of the current frame still show 1234. The next frame shows digits D,C,B,A = 100_0010, 011_0001, 110_0000, 000_1000.
- Simultaneous load and wrap tick: load 16'hFFFF on the wrap tick → the frame starting then shows F (011_1000) on all digits, and pending=0 afterwards.
- Blank and dp: blank=1 for 5 cycles → an=1111 from the following cycle. With dp_in=4'b0100, dp=0 only while an=1011.
- With LEADING_ZERO_BLANK_EN: value=16'h0050 → digits 3 and 2 show 111_1111, digit 1 shows 010_0100, digit 0 shows 000_0001. value=16'h0000 → only digit 0 shows "0".

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared definitions for the seven-segment scan driver:
//                segment bit ordering, the blank pattern and the active-low
//                hexadecimal segment table.
//                Segment vector layout: bit6=a, bit5=b, bit4=c, bit3=d,
//                bit2=e, bit1=f, bit0=g. A 0 lights the segment.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    // Field order of the packed struct fixes the bit order (a is the MSB).
    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
        logic e;
        logic f;
        logic g;
    } seg_bits_t;

    // All segments dark (active-low).
    localparam logic [6:0] SEG_OFF = 7'b111_1111;

    // Active-low hex glyphs, indexed by nibble value 0..F.
    localparam logic [0:15][6:0] SEG_TABLE = '{
        7'b000_0001,  // 0
        7'b100_1111,  // 1
        7'b001_0010,  // 2
        7'b000_0110,  // 3
        7'b100_1100,  // 4
        7'b010_0100,  // 5
        7'b010_0000,  // 6
        7'b000_1111,  // 7
        7'b000_0000,  // 8
        7'b000_0100,  // 9
        7'b000_1000,  // A
        7'b110_0000,  // b
        7'b011_0001,  // C
        7'b100_0010,  // d
        7'b011_0000,  // E
        7'b011_1000   // F
    };

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver_if
//  Description : Bus between the datapath and the seven-segment scan driver.
//                master : datapath side (drives value/load/dp_in/blank)
//                slave  : driver side (drives seg/dp/an/frame_start)
//                value       4*DIGITS  hex nibbles, nibble i -> digit i
//                load        1         capture value into staging
//                dp_in       DIGITS    decimal point request per digit
//                blank       1         force all anodes off
//                seg         7         segments, active-low, bit6=a
//                dp          1         decimal point, active-low
//                an          DIGITS    anode enables, active-low
//                frame_start 1         one-cycle pulse after scan wrap
//  Revision    : 1.0  initial release
// ============================================================================
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic [DIGITS-1:0]   dp_in;
    logic                blank;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;
    logic                frame_start;

    modport master (
        output value, load, dp_in, blank,
        input  seg, dp, an, frame_start
    );

    modport slave (
        input  value, load, dp_in, blank,
        output seg, dp, an, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/hex_seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : hex_seg7_decoder
//  Description : Combinational 4-bit hex to active-low 7-segment lookup.
//                nibble  in  4   hex digit value
//                seg     out 7   segments, active-low, bit6=a
//  Revision    : 1.0  initial release
// ============================================================================
module hex_seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_bits_t  seg
);
    assign seg = SEG_TABLE[nibble];
endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed common-anode seven-segment driver with scan
//                prescaler, frame-synchronous (tear-free) value loading,
//                per-digit decimal points and global blank.
//                Optional macro LEADING_ZERO_BLANK_EN: darkens zero digits
//                above the most significant non-zero nibble (digit 0 never).
//                clk    in   system clock
//                reset  in   synchronous, active-high
//                bus    slave modport of seg7_scan_driver_if
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    seg7_scan_driver_if.slave    bus
);
    localparam int IDX_W   = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;
    localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PRESC_W-1:0]  r_presc;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_staging;
    logic [4*DIGITS-1:0] r_shadow;
    logic                r_pending;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_an;
    logic                r_frame_start;

    logic                w_tick;
    logic                w_wrap;
    logic [3:0]          w_nibble;
    seg_bits_t           w_dec_seg;
    logic                w_suppress;

    assign w_tick   = (r_presc == PRESC_W'(SCAN_DIV - 1));
    assign w_wrap   = w_tick && (r_idx == IDX_W'(DIGITS - 1));
    assign w_nibble = r_shadow[{r_idx, 2'b00} +: 4];

    hex_seg7_decoder u_dec (
        .nibble (w_nibble),
        .seg    (w_dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is suppressed when it and every nibble above it are zero.
    logic [DIGITS-1:0] w_lz;
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_lz
            if (i == 0) begin : g_lsd
                assign w_lz[i] = 1'b0;
            end else begin : g_upper
                assign w_lz[i] = (r_shadow[4*DIGITS-1:4*i] == '0);
            end
        end
    endgenerate
    assign w_suppress = w_lz[r_idx];
`else
    assign w_suppress = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc       <= '0;
            r_idx         <= '0;
            r_staging     <= '0;
            r_shadow      <= '0;
            r_pending     <= 1'b0;
            r_seg         <= SEG_OFF;
            r_dp          <= 1'b1;
            r_an          <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end

            if (bus.load) begin
                r_staging <= bus.value;
            end

            // Shadow only changes at a frame boundary so a frame never shows
            // a mix of two values; a load on the wrap tick bypasses staging.
            if (w_wrap) begin
                if (bus.load) begin
                    r_shadow <= bus.value;
                end else if (r_pending) begin
                    r_shadow <= r_staging;
                end
                r_pending <= 1'b0;
            end else if (bus.load) begin
                r_pending <= 1'b1;
            end

            r_seg         <= w_suppress ? SEG_OFF : w_dec_seg;
            r_dp          <= ~bus.dp_in[r_idx];
            r_an          <= bus.blank ? '1 : ~(DIGITS'(1) << r_idx);
            r_frame_start <= w_wrap;
        end
    end

    assign bus.seg         = r_seg;
    assign bus.dp          = r_dp;
    assign bus.an          = r_an;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire
